// File: rtl/config_loader.sv
// Serial configuration loader: shifts an LSB-first word into a shadow register,
// checks an even-parity trailer bit, and only then commits the word to the tile bus.
module config_loader #(
   parameter int CONFIG_WIDTH = 24
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load_start,
   input  logic                    bit_in,
   input  logic                    bit_valid,
   output logic                    bit_ready,
   output logic [CONFIG_WIDTH-1:0] config_out,
   output logic                    config_valid,
   output logic                    busy,
   output logic                    error
);

   localparam int CNT_W = $clog2(CONFIG_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CONFIG_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_PARITY,
      ST_DONE,
      ST_ERROR
   } state_t;

   state_t                  state;
   state_t                  next_state;
   logic [CONFIG_WIDTH-1:0] shadow;
   logic [CNT_W-1:0]        count;
   logic                    accept;
   logic                    parity_ok;

   // Next-state logic; load_start restarts from any state and beats a same-cycle bit.
   always_comb begin
      next_state = state;
      bit_ready  = (state == ST_SHIFT) || (state == ST_PARITY);
      busy       = bit_ready;
      accept     = bit_valid && bit_ready && !load_start;
      parity_ok  = ~((^shadow) ^ bit_in);

      if (load_start) begin
         next_state = ST_SHIFT;
      end else begin
         case (state)
            ST_SHIFT: begin
               if (accept && (count == LAST_BIT)) begin
                  next_state = ST_PARITY;
               end
            end
            ST_PARITY: begin
               if (accept) begin
                  next_state = parity_ok ? ST_DONE : ST_ERROR;
               end
            end
            default: next_state = state;
         endcase
      end
   end

   // The committed word only moves on a good parity bit, so the tile never sees a partial load.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         shadow       <= '0;
         count        <= '0;
         config_out   <= '0;
         config_valid <= 1'b0;
         error        <= 1'b0;
      end else begin
         state <= next_state;
         if (load_start) begin
            count        <= '0;
            config_valid <= 1'b0;
            error        <= 1'b0;
         end else if (accept && (state == ST_SHIFT)) begin
            shadow <= {bit_in, shadow[CONFIG_WIDTH-1:1]};
            count  <= count + CNT_W'(1);
         end else if (accept && (state == ST_PARITY)) begin
            if (parity_ok) begin
               config_out   <= shadow;
               config_valid <= 1'b1;
            end else begin
               error <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter CONFIG_WIDTH, default 24: number of configuration bits delivered to one tile's config_in bus.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load_start  input  1  one-cycle request to begin (or restart) a configuration load.
REQ-005 bit_in  input  1  serial configuration data bit.
REQ-006 bit_valid  input  1  bit_in is valid this cycle.
REQ-007 bit_ready  output  1  loader accepts a bit this cycle; a bit transfers when bit_valid && bit_ready.
REQ-008 config_out  output  CONFIG_WIDTH  committed configuration word, drives the tile config_in bus.
REQ-009 config_valid  output  1  config_out holds a parity-checked committed word.
REQ-010 busy  output  1  high in SHIFT and PARITY states.
REQ-011 error  output  1  sticky parity-failure flag.

Function
REQ-012 States: IDLE, SHIFT, PARITY, DONE, ERROR; one-hot or binary encoding is an implementation choice.
REQ-013 Internal shadow register (CONFIG_WIDTH bits) and bit counter of width clog2(CONFIG_WIDTH+1) are maintained.
REQ-014 bit_ready is combinational: 1 in SHIFT and PARITY, 0 otherwise.
REQ-015 IDLE/DONE/ERROR + load_start: next state SHIFT, counter=0, config_valid=0, error=0; config_out unchanged.
REQ-016 SHIFT, accepted bit: shadow shifts right, bit_in enters MSB; after CONFIG_WIDTH bits the first received bit sits at shadow[0] (LSB-first stream).
REQ-017 SHIFT: counter increments per accepted bit; the accept with counter==CONFIG_WIDTH-1 moves to PARITY.
REQ-018 Cycles with bit_valid=0 in SHIFT/PARITY: no state, counter or shadow change (gaps allowed, unbounded).
REQ-019 PARITY, accepted bit: even parity -- if XOR(shadow, bit_in)==0 then on that same edge config_out<=shadow, config_valid<=1, state DONE.
REQ-020 PARITY, parity mismatch: state ERROR, error<=1, config_out and config_valid=0 retained as-is (config_out keeps previous committed word).
REQ-021 Latency: config_out/config_valid update on the edge that accepts the parity bit; total CONFIG_WIDTH+1 accepted bits per load.
REQ-022 load_start in SHIFT or PARITY: abort and restart -- counter=0, state SHIFT, shadow contents don't-care, config_out unchanged.
REQ-023 load_start and bit_valid in same SHIFT/PARITY cycle: load_start wins, the bit is discarded.
REQ-024 bit_valid outside SHIFT/PARITY: ignored.
REQ-025 config_out never changes except on a successful commit or reset; no partial word ever appears on config_out.
REQ-026 error remains 1 in ERROR until load_start or reset.

Reset
REQ-027 On reset: state IDLE, counter 0, shadow 0, config_out 0, config_valid 0, error 0; busy and bit_ready read 0 the following cycle.
REQ-028 reset asserted during any state, including mid-load or simultaneous with load_start, takes priority and yields REQ-027 values.

Verification (CONFIG_WIDTH=24)
REQ-029 load_start, then 24 bits of 0x000F0F LSB-first plus parity 0, bit_valid continuous -> config_out=0x000F0F and config_valid=1 after edge of 25th accepted bit, busy=0, error=0.
REQ-030 After REQ-029, load 0xABCDEF with parity bit 0 (wrong; popcount 17) -> error=1, config_valid=0, config_out still 0x000F0F.
REQ-031 Load 0x123456 (popcount 9, parity 1) with bit_valid toggling every other cycle -> config_out=0x123456, commit exactly at 25th accepted bit.
REQ-032 After 10 accepted bits, pulse load_start with bit_valid=1 same cycle, then full load 0x800001 parity 0 -> config_out=0x800001; aborted bits have no effect.
REQ-033 Assert reset after 12 accepted bits of a load -> next cycle config_out=0, config_valid=0, error=0, busy=0; bits sent while IDLE ignored.
REQ-034 Bench checks bit_ready==busy every cycle and config_out stable on all non-commit cycles.
